// File: rtl/match_controller_if.sv
// Bundles the frame/control inputs and the ball/score outputs of the pong match sequencer.
// The slave modport belongs to the controller; the master modport drives it.
interface match_controller_if;
  logic       frame_tick;
  logic       start;
  logic       pause;
  logic [1:0] ponto;
  logic       ball_load;
  logic       ball_run;
  logic       serve_dir;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       game_over;
  logic       winner;
  logic [2:0] state_dbg;

  modport master (
    output frame_tick, start, pause, ponto,
    input  ball_load, ball_run, serve_dir, score_l, score_r, game_over, winner, state_dbg
  );

  modport slave (
    input  frame_tick, start, pause, ponto,
    output ball_load, ball_run, serve_dir, score_l, score_r, game_over, winner, state_dbg
  );
endinterface

// File: rtl/match_controller.sv
// Rally/match sequencer: scores point codes once per occurrence, holds the ball for the
// serve delay, gates ball motion during live play and declares the winner at the target score.
module match_controller #(
  parameter int         SERVE_FRAMES = 60,
  parameter int         MAX_SCORE    = 9,
  parameter logic [1:0] CODE_MISS_L  = 2'b01,
  parameter logic [1:0] CODE_MISS_R  = 2'b11
) (
  input  logic               clock,
  input  logic               reset,
  match_controller_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERVE  = 3'd1,
    PLAY   = 3'd2,
    SCORED = 3'd3,
    OVER   = 3'd4
  } state_t;

  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [3:0] MAX_S      = 4'(MAX_SCORE);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] score_l_q, score_l_d;
  logic [3:0] score_r_q, score_r_d;
  logic       serve_dir_q, serve_dir_d;
  logic       winner_q, winner_d;
  logic       ball_load_q, ball_load_d;
  logic       ball_run_q, ball_run_d;
  logic       game_over_q, game_over_d;
  logic       start_q;
  logic [1:0] ponto_q;

  logic start_evt, miss_l_evt, miss_r_evt;

  assign start_evt  = bus.start & ~start_q;
  assign miss_l_evt = (bus.ponto == CODE_MISS_L) && (ponto_q != CODE_MISS_L);
  assign miss_r_evt = (bus.ponto == CODE_MISS_R) && (ponto_q != CODE_MISS_R);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;

    case (state_q)
      IDLE, OVER: begin
        if (start_evt) begin
          state_d     = SERVE;
          cnt_d       = 8'd0;
          score_l_d   = 4'd0;
          score_r_d   = 4'd0;
          serve_dir_d = 1'b0;
          winner_d    = 1'b0;
        end
      end
      SERVE: begin
        // Paused ticks are dropped entirely so the serve delay restarts nothing, it just waits.
        if (bus.frame_tick && !bus.pause) begin
          if (cnt_q == SERVE_LAST) begin
            state_d = PLAY;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      PLAY: begin
        if (miss_l_evt) begin
          score_r_d   = (score_r_q == 4'd15) ? score_r_q : score_r_q + 4'd1;
          serve_dir_d = 1'b0;
          state_d     = SCORED;
        end else if (miss_r_evt) begin
          score_l_d   = (score_l_q == 4'd15) ? score_l_q : score_l_q + 4'd1;
          serve_dir_d = 1'b1;
          state_d     = SCORED;
        end
      end
      SCORED: begin
        if (score_l_q == MAX_S || score_r_q == MAX_S) begin
          state_d  = OVER;
          winner_d = (score_r_q == MAX_S);
        end else begin
          state_d = SERVE;
          cnt_d   = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are derived from the next state so they line up with the state register.
    ball_load_d = (state_d != PLAY);
    ball_run_d  = (state_d == PLAY) && !bus.pause;
    game_over_d = (state_d == OVER);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      serve_dir_q <= 1'b0;
      winner_q    <= 1'b0;
      ball_load_q <= 1'b1;
      ball_run_q  <= 1'b0;
      game_over_q <= 1'b0;
      start_q     <= 1'b0;
      ponto_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      serve_dir_q <= serve_dir_d;
      winner_q    <= winner_d;
      ball_load_q <= ball_load_d;
      ball_run_q  <= ball_run_d;
      game_over_q <= game_over_d;
      start_q     <= bus.start;
      ponto_q     <= bus.ponto;
    end
  end

  assign bus.ball_load = ball_load_q;
  assign bus.ball_run  = ball_run_q;
  assign bus.serve_dir = serve_dir_q;
  assign bus.score_l   = score_l_q;
  assign bus.score_r   = score_r_q;
  assign bus.game_over = game_over_q;
  assign bus.winner    = winner_q;
  assign bus.state_dbg = state_q;
endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Rally/match sequencer for the pong datapath.
- Consumes the per-frame point code from the paddle/ball impact logic, keeps both players' scores and holds the ball at centre during the serve delay.
- Enables ball motion only during live play and declares game over at the target score.
- Sits between the impact block, the ball-motion block and the score display.

Parameters:
SERVE_FRAMES, 60, frame ticks the ball is held at centre before each serve (range 1..255)
MAX_SCORE, 9, score that ends the match (range 1..15)
CODE_MISS_L, 2'b01, point code meaning left paddle missed (point to right player)
CODE_MISS_R, 2'b11, point code meaning right paddle missed (point to left player)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low; clock clock
frame_tick  in  1  one-cycle pulse per video frame
start  in  1  start/restart button, synchronous level
pause  in  1  level; freezes play and serve countdown while high
ponto  in  2  point code from impact logic, held for many cycles
ball_load  out  1  1 = ball-motion block forces ball to centre
ball_run  out  1  1 = ball-motion block may advance the ball
serve_dir  out  1  0 = serve toward left, 1 = serve toward right
score_l  out  4  left player score
score_r  out  4  right player score
game_over  out  1  match finished
winner  out  1  0 = left won, 1 = right won; valid only while game_over=1
state_dbg  out  3  current state code

Behaviour:
- All outputs are registered. All logic is clocked on the rising edge of clock.
- Reset (reset=0 at an edge), from any state including mid-rally:
  - state=IDLE, score_l=score_r=0, ball_load=1, ball_run=0, serve_dir=0, game_over=0, winner=0.
  - serve counter=0; start_q=0; ponto_q=2'b00.
- Edge detection:
  - start_evt = start & ~start_q.
  - miss_l_evt = (ponto==CODE_MISS_L) & (ponto_q!=CODE_MISS_L); miss_r_evt analogous.
  - start_q and ponto_q update every cycle in every state.
  - A held code counts exactly once.
- State encoding (state_dbg): IDLE=0, SERVE=1, PLAY=2, SCORED=3, OVER=4.
- IDLE: ball_load=1, ball_run=0.
  - start_evt -> SERVE; scores cleared; counter=0; serve_dir=0.
- SERVE: ball_load=1, ball_run=0.
  - On frame_tick with pause=0: counter increments.
  - On the frame_tick where counter==SERVE_FRAMES-1 (pause=0): -> PLAY; counter cleared.
  - Ticks arriving while pause=1 are ignored.
- PLAY: ball_load=0, ball_run=~pause.
  - miss_l_evt: score_r+1, serve_dir=0; -> SCORED on the same edge, and ball_run=0 from that edge.
  - miss_r_evt: score_l+1, serve_dir=1; same transition and ball_run behaviour.
  - Both events in one cycle cannot occur (single 2-bit code).
  - Events are counted even while paused.
  - start_evt is ignored.
  - Event latency: event present at edge N -> score visible after edge N.
- SCORED: exactly one cycle, ball_load=1, ball_run=0.
  - If score_l==MAX_SCORE or score_r==MAX_SCORE: -> OVER; game_over=1; winner = (score_r==MAX_SCORE).
  - Otherwise -> SERVE with counter=0.
- OVER: ball_load=1, ball_run=0, game_over=1; scores held.
  - start_evt -> SERVE; scores cleared; game_over=0; winner=0; serve_dir=0.
- Miss events outside PLAY are ignored but still update ponto_q, so a code held across the transition into PLAY does not score.
- Scores saturate at 15; they cannot increment past MAX_SCORE in normal flow.
- start held high continuously produces only one start_evt.

Test Plan (SERVE_FRAMES=3, MAX_SCORE=2):
1. Reset low mid-PLAY with score_l=1 -> next edge state_dbg=0, scores 0, ball_load=1, ball_run=0, game_over=0.
2. IDLE, pulse start, then 3 frame_ticks spaced 5 cycles apart -> state_dbg=1 until the edge of the 3rd tick, then 2; ball_run=1 the cycle after.
3. PLAY, ponto=01 held 40 cycles -> score_r 0->1 exactly once, serve_dir=0, state 2->3->1; ball_run=0 from the event edge.
4. ponto=11 already held when entering PLAY -> no score change; ponto goes to 00 then 11 -> score_l+1, serve_dir=1.
5. score_r=1, miss_l_evt -> SCORED then OVER: game_over=1, winner=1, score_r=2; further ponto codes change nothing; start pulse -> state 1, scores 0, game_over=0.
6. SERVE with pause=1 across 5 frame_ticks -> counter frozen, state stays 1; pause=0 then 3 ticks -> PLAY; pause=1 in PLAY -> ball_run=0, ball_load=0.
